// File: rtl/posit_accum_raw_mc_if.sv
// Operand/result handshake bundle for the multi-channel raw posit accumulator.
interface posit_accum_raw_mc_if #(
    parameter int SCALE_W   = 8,
    parameter int FBITS_IN  = 27,
    parameter int FBITS_ACC = 64,
    parameter int CHANNELS  = 4,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CH_W-1:0]              in_ch;
    logic                         in_last;
    logic [SCALE_W+FBITS_IN+2:0]  in_data;
    logic                         out_valid;
    logic [CH_W-1:0]              out_ch;
    logic [SCALE_W+FBITS_ACC+2:0] out_data;

    modport master (
        output in_valid, in_ch, in_last, in_data,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_last, in_data,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/posit_accum_raw_mc.sv
// Multi-channel ES2 raw posit accumulator: tagged operands, 4-stage add,
// per-channel busy interlock, sum emitted on the last operand.
module posit_accum_raw_mc #(
    parameter int SCALE_W   = 8,
    parameter int FBITS_IN  = 27,
    parameter int FBITS_ACC = 64,
    parameter int CHANNELS  = 4,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    posit_accum_raw_mc_if.slave bus
);

    localparam int M    = FBITS_ACC + 4;
    localparam int LZ_W = $clog2(M + 1);
    localparam int SW   = SCALE_W + LZ_W + 1;

    typedef struct packed {
        logic                      sgn;
        logic signed [SCALE_W-1:0] scale;
        logic [FBITS_ACC-1:0]      frac;
        logic                      inf;
        logic                      zero;
    } raw_t;

    typedef struct packed {
        logic                      sgn;
        logic signed [SCALE_W-1:0] scale;
        logic [FBITS_IN-1:0]       frac;
        logic                      inf;
        logic                      zero;
    } raw_in_t;

    typedef struct packed {
        logic            last;
        logic [CH_W-1:0] ch;
        raw_t            a;
        raw_t            b;
    } s0_t;

    typedef struct packed {
        logic                      last;
        logic [CH_W-1:0]           ch;
        logic                      byp;
        raw_t                      bypv;
        logic                      sgn;
        logic                      sub;
        logic signed [SCALE_W-1:0] scale;
        logic [M-1:0]              mh;
        logic [M-1:0]              ml;
    } s1_t;

    typedef struct packed {
        logic                      last;
        logic [CH_W-1:0]           ch;
        logic                      byp;
        raw_t                      bypv;
        logic                      sgn;
        logic signed [SCALE_W-1:0] scale;
        logic [M:0]                sum;
        logic [LZ_W-1:0]           lz;
    } s2_t;

    localparam raw_t RAW_ZERO = '{
        sgn: 1'b0, scale: '0, frac: '0, inf: 1'b0, zero: 1'b1
    };
    localparam raw_t RAW_INF = '{
        sgn: 1'b0, scale: '0, frac: '0, inf: 1'b1, zero: 1'b0
    };
    localparam logic signed [SW-1:0] SC_MAX = SW'(2 ** (SCALE_W - 1) - 1);
    localparam logic signed [SW-1:0] SC_MIN = SW'(-(2 ** (SCALE_W - 1)));
    localparam logic [CH_W:0]        CH_LIM = (CH_W + 1)'(CHANNELS);

    function automatic logic [LZ_W-1:0] lzc(input logic [M-1:0] v);
        lzc = LZ_W'(M);
        for (int i = 0; i < M; i++) begin
            if (v[i]) lzc = LZ_W'(M - 1 - i);
        end
    endfunction

    raw_t                acc [CHANNELS];
    logic [CHANNELS-1:0] busy;

    raw_in_t op;
    raw_t    op_ext;
    raw_t    acc_rd;
    logic    ch_ok;
    logic    busy_sel;
    logic    accept;

    logic v0, v1, v2;
    s0_t  p0;
    s1_t  p1, s1_n;
    s2_t  p2, s2_n;

    assign op    = raw_in_t'(bus.in_data);
    assign ch_ok = {1'b0, bus.in_ch} < CH_LIM;

    always_comb begin
        busy_sel = 1'b0;
        acc_rd   = RAW_ZERO;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_ch == CH_W'(i)) begin
                busy_sel = busy[i];
                acc_rd   = acc[i];
            end
        end
    end

    // Out-of-range channels handshake normally but never enter the pipe.
    assign bus.in_ready = ~clr & ~busy_sel;
    assign accept       = bus.in_valid & bus.in_ready & ch_ok;

    always_comb begin
        op_ext       = RAW_ZERO;
        op_ext.sgn   = op.sgn;
        op_ext.scale = op.scale;
        op_ext.frac  = '0;
        op_ext.frac[FBITS_ACC-1 -: FBITS_IN] = op.frac;
        op_ext.inf   = op.inf;
        op_ext.zero  = op.zero;
    end

    // S1: magnitude order and alignment; specials bypass the datapath.
    logic             b_hi;
    raw_t             hi, lo;
    logic [SCALE_W:0] diff;

    always_comb begin
        b_hi = ($signed(p0.b.scale) > $signed(p0.a.scale)) ||
               (p0.b.scale == p0.a.scale && p0.b.frac >= p0.a.frac);
        hi   = b_hi ? p0.b : p0.a;
        lo   = b_hi ? p0.a : p0.b;
        diff = {hi.scale[SCALE_W-1], hi.scale} -
               {lo.scale[SCALE_W-1], lo.scale};

        s1_n       = '0;
        s1_n.last  = p0.last;
        s1_n.ch    = p0.ch;
        s1_n.sgn   = hi.sgn;
        s1_n.sub   = hi.sgn ^ lo.sgn;
        s1_n.scale = hi.scale;
        s1_n.mh    = {1'b1, hi.frac, 3'b000};
        s1_n.ml    = '0;
        if (int'(diff) < M) s1_n.ml = {1'b1, lo.frac, 3'b000} >> diff;

        s1_n.byp  = 1'b1;
        s1_n.bypv = RAW_ZERO;
        if (p0.a.inf || p0.b.inf) s1_n.bypv = RAW_INF;
        else if (p0.b.zero)       s1_n.bypv = p0.a;
        else if (p0.a.zero)       s1_n.bypv = p0.b;
        else                      s1_n.byp  = 1'b0;
    end

    always_comb begin
        s2_n       = '0;
        s2_n.last  = p1.last;
        s2_n.ch    = p1.ch;
        s2_n.byp   = p1.byp;
        s2_n.bypv  = p1.bypv;
        s2_n.sgn   = p1.sgn;
        s2_n.scale = p1.scale;
        if (p1.sub) s2_n.sum = {1'b0, p1.mh} - {1'b0, p1.ml};
        else        s2_n.sum = {1'b0, p1.mh} + {1'b0, p1.ml};
        s2_n.lz    = lzc(s2_n.sum[M-1:0]);
    end

    // S3: normalise, truncate, saturate or flush.
    logic signed [SW-1:0] sc_ext;
    logic signed [SW-1:0] sc_new;
    logic [M-1:0]         norm;
    raw_t                 res;

    always_comb begin
        sc_ext = {{(SW - SCALE_W){p2.scale[SCALE_W-1]}}, p2.scale};
        norm   = p2.sum[M-1:0] << p2.lz;
        res      = RAW_ZERO;
        res.zero = 1'b0;
        res.sgn  = p2.sgn;
        if (p2.sum[M]) begin
            sc_new   = sc_ext + {{(SW - 1){1'b0}}, 1'b1};
            res.frac = p2.sum[M-1 -: FBITS_ACC];
        end else begin
            sc_new   = sc_ext - {{(SW - LZ_W){1'b0}}, p2.lz};
            res.frac = norm[M-2 -: FBITS_ACC];
        end
        res.scale = sc_new[SCALE_W-1:0];
        if (p2.byp) begin
            res = p2.bypv;
        end else if (p2.sum == '0 || sc_new < SC_MIN) begin
            res = RAW_ZERO;
        end else if (sc_new > SC_MAX) begin
            res.scale = SC_MAX[SCALE_W-1:0];
            res.frac  = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= RAW_ZERO;
            busy          <= '0;
            v0            <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_data  <= RAW_ZERO;
        end else if (clr) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= RAW_ZERO;
            busy          <= '0;
            v0            <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            v0            <= accept;
            v1            <= v0;
            v2            <= v1;
            bus.out_valid <= v2 & p2.last;
            if (v2 && p2.last) begin
                bus.out_ch   <= p2.ch;
                bus.out_data <= res;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (v2 && p2.ch == CH_W'(i)) begin
                    acc[i]  <= p2.last ? RAW_ZERO : res;
                    busy[i] <= 1'b0;
                end
                if (accept && bus.in_ch == CH_W'(i)) busy[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
        end else begin
            if (accept) begin
                p0.last <= bus.in_last;
                p0.ch   <= bus.in_ch;
                p0.a    <= acc_rd;
                p0.b    <= op_ext;
            end
            p1 <= s1_n;
            p2 <= s2_n;
        end
    end

endmodule

// File: tb/tb_posit_accum_raw_mc.sv
// Scoreboard bench for the multi-channel raw posit accumulator.
module tb_posit_accum_raw_mc;

    localparam int SCALE_W   = 8;
    localparam int FBITS_IN  = 27;
    localparam int FBITS_ACC = 64;
    localparam int CHANNELS  = 4;
    localparam int CH_W      = 2;
    localparam int IN_W      = SCALE_W + FBITS_IN + 3;
    localparam int OUT_W     = SCALE_W + FBITS_ACC + 3;

    typedef logic [IN_W-1:0]       in_t;
    typedef logic [OUT_W-1:0]      out_t;
    typedef logic [CH_W+OUT_W-1:0] exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   last_waits = 0;
    exp_t sb_q[$];
    exp_t mon_exp;

    posit_accum_raw_mc_if #(
        .SCALE_W(SCALE_W), .FBITS_IN(FBITS_IN), .FBITS_ACC(FBITS_ACC),
        .CHANNELS(CHANNELS), .CH_W(CH_W)
    ) bus ();

    posit_accum_raw_mc #(
        .SCALE_W(SCALE_W), .FBITS_IN(FBITS_IN), .FBITS_ACC(FBITS_ACC),
        .CHANNELS(CHANNELS), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic sgn, input logic [7:0] sc,
                                  input logic [26:0] fr, input logic inf,
                                  input logic zero);
        return {sgn, sc, fr, inf, zero};
    endfunction

    function automatic out_t mk_out(input logic sgn, input logic [7:0] sc,
                                    input logic [63:0] fr, input logic inf,
                                    input logic zero);
        return {sgn, sc, fr, inf, zero};
    endfunction

    function automatic in_t one();
        return mk_in(1'b0, 8'h00, 27'h0, 1'b0, 1'b0);
    endfunction

    function automatic out_t one_out();
        return mk_out(1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
    endfunction

    function automatic out_t zero_out();
        return mk_out(1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got ch=%0d data=%h, none required",
                         bus.out_ch, bus.out_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({bus.out_ch, bus.out_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL out_result: got %h want %h",
                             {bus.out_ch, bus.out_data}, mon_exp);
                end
            end
        end
    end

    task automatic push(input logic [CH_W-1:0] ch, input out_t d);
        sb_q.push_back({ch, d});
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic last,
                        input in_t d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        bus.in_last  = last;
        bus.in_data  = d;
        last_waits   = 0;
        #1;
        while (!bus.in_ready && last_waits < 20) begin
            @(negedge clk);
            #1;
            last_waits++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: ch=%0d in_ready=%b want 1",
                     ch, bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding=%0d want 0", sb_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if (bus.out_ch !== 2'd0) begin
            bad++;
            $display("FAIL reset_ch: got %0d want 0", bus.out_ch);
        end
        total++;
        if (bus.out_data !== zero_out()) begin
            bad++;
            $display("FAIL reset_data: got %h want %h", bus.out_data, zero_out());
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic_sum();
        int lat = 0;
        push(2'd0, mk_out(1'b0, 8'h01, 64'h0, 1'b0, 1'b0));
        send(2'd0, 1'b0, one());
        send(2'd0, 1'b1, one());
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) lat = k;
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL latency: got %0d want 3", lat);
        end
        push(2'd0, one_out());
        send(2'd0, 1'b1, one());
        wait_idle();
    endtask

    task automatic test_cancel();
        push(2'd2, zero_out());
        send(2'd2, 1'b0, mk_in(1'b0, 8'h00, 27'h4000000, 1'b0, 1'b0));
        send(2'd2, 1'b1, mk_in(1'b1, 8'h00, 27'h4000000, 1'b0, 1'b0));
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic want;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd1;
        bus.in_last  = 1'b0;
        bus.in_data  = one();
        for (int i = 0; i < 8; i++) begin
            #1;
            want = (i % 4 == 0);
            total++;
            if (bus.in_ready !== want) begin
                bad++;
                $display("FAIL b2b_ready: cycle %0d got %b want %b",
                         i, bus.in_ready, want);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        push(2'd1, mk_out(1'b0, 8'h01, 64'h8000_0000_0000_0000, 1'b0, 1'b0));
        send(2'd1, 1'b1, one());
        wait_idle();
        for (int c = 0; c < CHANNELS; c++) begin
            push(CH_W'(c), one_out());
            send(CH_W'(c), 1'b1, one());
            total++;
            if (last_waits != 0) begin
                bad++;
                $display("FAIL multi_ch_rate: ch=%0d waits=%0d want 0",
                         c, last_waits);
            end
        end
        wait_idle();
    endtask

    task automatic test_align_specials();
        send(2'd0, 1'b0, one());
        push(2'd0, one_out());
        send(2'd0, 1'b1, mk_in(1'b0, 8'h9c, 27'h0, 1'b0, 1'b0));
        send(2'd1, 1'b0, one());
        push(2'd1, mk_out(1'b0, 8'h00, 64'h1, 1'b0, 1'b0));
        send(2'd1, 1'b1, mk_in(1'b0, 8'hc0, 27'h0, 1'b0, 1'b0));
        send(2'd2, 1'b0, mk_in(1'b0, 8'h03, 27'h2000000, 1'b0, 1'b0));
        push(2'd2, mk_out(1'b0, 8'h03, 64'h4000_0000_0000_0000, 1'b0, 1'b0));
        send(2'd2, 1'b1, mk_in(1'b0, 8'h00, 27'h0, 1'b0, 1'b1));
        send(2'd3, 1'b0, mk_in(1'b0, 8'h7f, 27'h0, 1'b0, 1'b0));
        push(2'd3, mk_out(1'b0, 8'h7f, '1, 1'b0, 1'b0));
        send(2'd3, 1'b1, mk_in(1'b0, 8'h7f, 27'h0, 1'b0, 1'b0));
        send(2'd0, 1'b0, mk_in(1'b0, 8'h80, 27'h4000000, 1'b0, 1'b0));
        push(2'd0, zero_out());
        send(2'd0, 1'b1, mk_in(1'b1, 8'h80, 27'h0, 1'b0, 1'b0));
        wait_idle();
    endtask

    task automatic test_inf();
        push(2'd3, mk_out(1'b0, 8'h00, 64'h0, 1'b1, 1'b0));
        send(2'd3, 1'b0, mk_in(1'b0, 8'h00, 27'h0, 1'b1, 1'b0));
        send(2'd3, 1'b1, one());
        push(2'd3, one_out());
        send(2'd3, 1'b1, one());
        wait_idle();
    endtask

    task automatic test_abort(input logic use_rst);
        send(2'd3, 1'b0, one());
        repeat (4) @(negedge clk);
        send(2'd0, 1'b1, one());
        send(2'd1, 1'b1, one());
        send(2'd2, 1'b1, one());
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         clr = 1'b1;
        #1;
        if (!use_rst) begin
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL clr_ready: got %b want 0", bus.in_ready);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        repeat (6) @(negedge clk);
        for (int c = 0; c < CHANNELS; c++) begin
            bus.in_ch = CH_W'(c);
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_busy: ch=%0d in_ready=%b want 1",
                         c, bus.in_ready);
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            push(CH_W'(c), one_out());
            send(CH_W'(c), 1'b1, one());
        end
        wait_idle();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic_sum();
        test_cancel();
        test_back_to_back();
        test_align_specials();
        test_inf();
        test_abort(1'b1);
        test_abort(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
                 total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/posit_accum_raw_mc.md
Name: posit_accum_raw_mc

Overview:
- Parametrised, multi-channel successor to the single-stream ES2 raw-format posit accumulator.
- Holds CHANNELS independent accumulators in a register file and accepts one tagged raw operand per cycle through a valid/ready handshake.
- Adds each operand into its channel with a fixed 4-stage pipeline and emits a channel's sum on a last-flagged operand.
- Sits between the posit decode/multiply stages and the final raw-to-posit rounding/encode stage.

Parameters:
- SCALE_W, 8, signed scale width (regime+exponent).
- FBITS_IN, 27, input fraction bits (hidden bit excluded).
- FBITS_ACC, 64, accumulator fraction bits; must be >= FBITS_IN.
- CHANNELS, 4, number of independent accumulators; >= 1.
- CH_W, max(1,$clog2(CHANNELS)), channel-id width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of all channels.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid & in_ready.
- in_ch  in  CH_W  target channel.
- in_last  in  1  final operand of the current sum.
- in_data  in  SCALE_W+FBITS_IN+3  raw operand {sgn, scale, fraction, inf, zero}.
- out_valid  out  1  single-cycle result strobe.
- out_ch  out  CH_W  channel of the result.
- out_data  out  SCALE_W+FBITS_ACC+3  raw sum {sgn, scale, fraction, inf, zero}.

Behaviour:
- Reset (asynchronous, active-high):
  - Every accumulator becomes the canonical zero: sgn 0, scale 0, fraction 0, inf 0, zero 1.
  - All busy bits clear; all pipeline valids clear.
  - out_valid=0, out_ch=0, out_data=canonical zero.
  - Reset mid-operation discards all in-flight work; nothing is emitted.
- Acceptance:
  - in_ready = ~clr & ~busy[in_ch].
  - An in_ch >= CHANNELS is accepted and dropped; no state changes.
  - On accept, busy[in_ch] sets.
- Pipeline, for an operand accepted at edge t:
  - S0 (edge t): read the accumulator, zero-extend the operand fraction to FBITS_ACC, register both.
  - S1 (edge t+1): order operands by magnitude. Compare scale first, then fraction; equal magnitudes take the operand as "hi". Right-shift the smaller by the scale difference over hidden+fraction+3 guard bits. Shifts >= FBITS_ACC+4 produce 0. No sticky bit.
  - S2 (edge t+2): add if signs are equal, else subtract (hi-low). Produce carry+hidden+FBITS_ACC+3 bits and a leading-one position.
  - S3 (edge t+3): normalise. A carry shifts right 1 and adds 1 to scale; otherwise shift left by the leading-zero count and subtract it from scale. Truncate to FBITS_ACC (no rounding). The result sgn is the hi sgn.
- Writeback and output, same edge t+3:
  - Write the result back; clear busy[ch].
  - If last: out_valid=1, out_ch=ch, out_data=result; the channel resets to canonical zero instead of storing the result.
  - The same channel is accepted again from the cycle after t+3, so same-channel throughput is 1 per 4 cycles; distinct channels sustain 1 per cycle.
  - out_valid is 0 in all other cycles.
- Special cases:
  - Zero operand: accumulator unchanged (still counts for last).
  - Exact cancellation: canonical zero with sgn 0.
  - Inf operand or inf accumulator gives inf=1, zero=0, sgn=0, scale=0, fraction=0. Inf stays sticky until last or clr.
  - Scale overflow saturates to max scale with fraction all ones.
  - Scale underflow below min scale flushes to canonical zero.
- clr:
  - Takes effect on the next edge: all accumulators become zero and busy clears.
  - In-flight operations are cancelled and produce no writeback or out_valid.
  - in_ready=0 while clr=1.
  - clr together with rst: rst dominates.

Test Plan:
- Reset, then add 1.0 (sgn0 scale0 frac0) ×2 to ch0 with last on the 2nd:
  - out_valid exactly 3 cycles after the 2nd accept, out_ch=0.
  - out_data: scale 1, fraction 0, zero 0.
  - ch0 then holds canonical zero.
- Add 1.5 (frac MSB=1) then -1.5 with last on ch2: out_data is canonical zero, sgn 0.
- Back-to-back operands to ch1 with in_valid held high:
  - in_ready low for 3 cycles after each accept.
  - 4 operands to ch0..ch3 on consecutive cycles are accepted at 1/cycle.
- Add 2^0 + 2^-100 (scale -100) on ch0, last: result scale 0, fraction 0 (shift ≥ FBITS_ACC+4 yields 0).
- Inf on ch3, then 1.0 with last: out_data inf=1, zero=0. The next sum on ch3, 1.0 with last, returns scale 0, inf 0.
- Assert rst or clr with 3 operations in flight: no out_valid follows, all busy bits clear, and the next 1.0 with last on each channel returns scale 0.
